// File: rtl/aia_msi_gen_if.sv
// MSI write channel between the generator (master) and the interrupt-file window (slave).
interface aia_msi_gen_if #(
    parameter int unsigned AddrWidth = 64
);
    logic                 msi_valid_o;
    logic                 msi_ready_i;
    logic [AddrWidth-1:0] msi_addr_o;
    logic [31:0]          msi_data_o;

    modport master (
        output msi_valid_o,
        output msi_addr_o,
        output msi_data_o,
        input  msi_ready_i
    );

    modport slave (
        input  msi_valid_o,
        input  msi_addr_o,
        input  msi_data_o,
        output msi_ready_i
    );
endinterface

// File: rtl/aia_msi_gen.sv
// AIA MSI generator: wired sources -> pending bits -> fixed-priority pick -> one MSI write.
// Optional level-triggered sources are built only when AIA_MSI_LEVEL_EN is defined.
module aia_msi_gen #(
    parameter int unsigned NrSources   = 30,
    parameter int unsigned NrIntpFiles = 2,
    parameter int unsigned AddrWidth   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NrSources-1:0]         irq_src_i,
    input  logic                         domain_ie_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NrSources)-1:0] cfg_idx_i,
    input  logic [15:0]                  cfg_data_i,
    input  logic [AddrWidth-1:0]         msi_base_i,
    aia_msi_gen_if.master                msi,
    output logic                         busy_o
);
    localparam int unsigned IdxW      = $clog2(NrSources);
    localparam int unsigned EiidW     = 11;
    localparam int unsigned FileW     = 3;
    localparam int unsigned PageShift = 12;

    typedef enum logic {StIdle = 1'b0, StSend = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        sel_q, sel_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic [NrSources-1:0]   pend_q, pend_d;
    logic [NrSources-1:0]   prev_q, prev_d;
    logic [NrSources-1:0]   en_q, en_d;
    logic [EiidW-1:0]       eiid_q [NrSources];
    logic [EiidW-1:0]       eiid_d [NrSources];
    logic [FileW-1:0]       file_q [NrSources];
    logic [FileW-1:0]       file_d [NrSources];
`ifdef AIA_MSI_LEVEL_EN
    logic [NrSources-1:0]   mode_q, mode_d;
`else
    logic                   unused_mode;
    assign unused_mode = cfg_data_i[14];
`endif

    logic [NrSources-1:0]   active_c;
    logic [NrSources-1:0]   set_c;
    logic [NrSources-1:0]   clr_c;
    logic [NrSources-1:0]   cand_c;
    logic                   win_valid_c;
    logic [IdxW-1:0]        win_idx_c;

    // Source table update; out-of-range indices are dropped
    always_comb begin
        en_d   = en_q;
        eiid_d = eiid_q;
        file_d = file_q;
`ifdef AIA_MSI_LEVEL_EN
        mode_d = mode_q;
`endif
        if (cfg_we_i && (32'(cfg_idx_i) < NrSources)) begin
            en_d[cfg_idx_i]   = cfg_data_i[15];
            eiid_d[cfg_idx_i] = cfg_data_i[10:0];
            file_d[cfg_idx_i] = cfg_data_i[13:11];
`ifdef AIA_MSI_LEVEL_EN
            mode_d[cfg_idx_i] = cfg_data_i[14];
`endif
        end
    end

    // Per-source qualification and set events
    always_comb begin
        active_c = '0;
        set_c    = '0;
        for (int i = 0; i < int'(NrSources); i++) begin
            active_c[i] = en_q[i] && (eiid_q[i] != '0) && (32'(file_q[i]) < NrIntpFiles);
`ifdef AIA_MSI_LEVEL_EN
            set_c[i]    = mode_q[i] ? irq_src_i[i] : (irq_src_i[i] && !prev_q[i]);
`else
            set_c[i]    = irq_src_i[i] && !prev_q[i];
`endif
        end
    end

    // Lowest source number wins: scan downward so the last hit is the lowest
    always_comb begin
        cand_c      = pend_q & active_c;
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        for (int i = int'(NrSources) - 1; i >= 0; i--) begin
            if (cand_c[i]) begin
                win_valid_c = 1'b1;
                win_idx_c   = IdxW'(i);
            end
        end
    end

    // Next-state and message latch; a set in the acceptance cycle overrides the clear
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        clr_c   = '0;
        unique case (state_q)
            StIdle: begin
                if (domain_ie_i && win_valid_c) begin
                    sel_d   = win_idx_c;
                    addr_d  = msi_base_i + (AddrWidth'(file_q[win_idx_c]) << PageShift);
                    data_d  = 32'(eiid_q[win_idx_c]);
                    state_d = StSend;
                end
            end
            StSend: begin
                if (msi.msi_ready_i) begin
                    clr_c[sel_q] = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        pend_d = ((pend_q & ~clr_c) | set_c) & active_c;
        prev_d = irq_src_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            en_q    <= '0;
            eiid_q  <= '{default: '0};
            file_q  <= '{default: '0};
`ifdef AIA_MSI_LEVEL_EN
            mode_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            en_q    <= en_d;
            eiid_q  <= eiid_d;
            file_q  <= file_d;
`ifdef AIA_MSI_LEVEL_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign msi.msi_valid_o = (state_q == StSend);
    assign msi.msi_addr_o  = addr_q;
    assign msi.msi_data_o  = data_q;
    assign busy_o          = (state_q == StSend);

endmodule

// File: tb/tb_aia_msi_gen.sv
// Directed + random bench for aia_msi_gen against a spec-level reference model.
module tb_aia_msi_gen;
    localparam int NS = 30;
    localparam int NF = 2;
`ifdef AIA_MSI_LEVEL_EN
    localparam bit LevelEn = 1'b1;
`else
    localparam bit LevelEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] irq_src;
    logic        ie, we;
    logic [4:0]  idx;
    logic [15:0] cdata;
    logic [63:0] base;
    logic        busy;

    aia_msi_gen_if #(.AddrWidth(64)) msi_if ();

    aia_msi_gen #(.NrSources(NS), .NrIntpFiles(NF), .AddrWidth(64)) dut (
        .clk_i(clk), .rst_i(rst), .irq_src_i(irq_src), .domain_ie_i(ie),
        .cfg_we_i(we), .cfg_idx_i(idx), .cfg_data_i(cdata), .msi_base_i(base),
        .msi(msi_if), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_msi = 0;
    int n0;
    int m_acc = 0;
    int acc_q[$];

    // Reference model state, in spec terms
    bit          m_en[NS];
    int          m_eiid[NS];
    int          m_file[NS];
    bit          m_mode[NS];
    bit          m_pend[NS];
    bit          m_prev[NS];
    bit          m_busy;
    int          m_src;
    logic [63:0] m_addr;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_update();
        bit act[NS];
        bit set[NS];
        int clr_src;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_en[i] = 0; m_eiid[i] = 0; m_file[i] = 0; m_mode[i] = 0;
                m_pend[i] = 0; m_prev[i] = 0;
            end
            m_busy = 0; m_src = 0; m_addr = '0; m_data = '0;
            return;
        end
        for (int i = 0; i < NS; i++) begin
            act[i] = m_en[i] && (m_eiid[i] != 0) && (m_file[i] < NF);
            set[i] = irq_src[i] && ((LevelEn && m_mode[i]) || !m_prev[i]);
        end
        clr_src = -1;
        if (m_busy) begin
            if (msi_if.msi_ready_i) begin
                m_acc++;
                clr_src = m_src;
                m_busy  = 0;
            end
        end else if (ie) begin
            for (int i = 0; i < NS; i++) begin
                if (m_pend[i] && act[i]) begin
                    m_busy = 1;
                    m_src  = i;
                    m_addr = base + 64'(m_file[i]) * 64'h1000;
                    m_data = 32'(m_eiid[i]);
                    break;
                end
            end
        end
        for (int i = 0; i < NS; i++)
            m_pend[i] = act[i] && (set[i] || (m_pend[i] && i != clr_src));
        if (we && int'(idx) < NS) begin
            m_eiid[idx] = int'(cdata[10:0]);
            m_file[idx] = int'(cdata[13:11]);
            m_mode[idx] = cdata[14];
            m_en[idx]   = cdata[15];
        end
        for (int i = 0; i < NS; i++) m_prev[i] = irq_src[i];
    endfunction

    task automatic compare();
        chk("valid", 64'(msi_if.msi_valid_o), 64'(m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        if (m_busy) begin
            chk("addr", msi_if.msi_addr_o, m_addr);
            chk("data", 64'(msi_if.msi_data_o), 64'(m_data));
        end
    endtask

    // One clock: record handshake, advance model with current inputs, check after the edge
    task automatic step();
        if (msi_if.msi_valid_o === 1'b1 && msi_if.msi_ready_i === 1'b1) begin
            n_msi++;
            acc_q.push_back(int'(msi_if.msi_data_o));
        end
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input int i, input logic [15:0] d);
        we = 1'b1; idx = 5'(i); cdata = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; ie = 1'b1; we = 1'b0; idx = '0; cdata = '0;
        base = 64'h2800_0000; msi_if.msi_ready_i = 1'b0;
        step(); step();
        chk("rst_valid", 64'(msi_if.msi_valid_o), 64'd0);
        chk("rst_addr", msi_if.msi_addr_o, 64'd0);
        chk("rst_data", 64'(msi_if.msi_data_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();

        // Single edge on source 5 -> one MSI to file 1
        wr(4, 16'h880A);
        msi_if.msi_ready_i = 1'b1; n0 = n_msi;
        irq_src[4] = 1'b1; step();
        chk("t1_pend_cycle_valid", 64'(msi_if.msi_valid_o), 64'd0);
        step();
        chk("t1_valid", 64'(msi_if.msi_valid_o), 64'd1);
        chk("t1_addr", msi_if.msi_addr_o, 64'h2800_1000);
        chk("t1_data", 64'(msi_if.msi_data_o), 64'd10);
        step();
        chk("t1_drop", 64'(msi_if.msi_valid_o), 64'd0);
        repeat (4) step();
        chk("t1_count", 64'(n_msi - n0), 64'd1);
        irq_src[4] = 1'b0; step();

        // Sources 3 and 7 together -> 3 first, 7 two cycles after acceptance
        wr(2, 16'h8003); wr(6, 16'h8007);
        irq_src[2] = 1'b1; irq_src[6] = 1'b1;
        step(); step();
        chk("t2_first", 64'(msi_if.msi_data_o), 64'd3);
        chk("t2_first_addr", msi_if.msi_addr_o, 64'h2800_0000);
        step();
        chk("t2_gap", 64'(msi_if.msi_valid_o), 64'd0);
        step();
        chk("t2_second_v", 64'(msi_if.msi_valid_o), 64'd1);
        chk("t2_second", 64'(msi_if.msi_data_o), 64'd7);
        step();
        irq_src[2] = 1'b0; irq_src[6] = 1'b0; step();

        // Stalled message is immutable while its entry is rewritten
        msi_if.msi_ready_i = 1'b0;
        irq_src[2] = 1'b1; step(); step();
        chk("t3_valid", 64'(msi_if.msi_valid_o), 64'd1);
        wr(2, 16'h8014);
        repeat (18) step();
        chk("t3_hold_v", 64'(msi_if.msi_valid_o), 64'd1);
        chk("t3_hold_d", 64'(msi_if.msi_data_o), 64'd3);
        chk("t3_hold_a", msi_if.msi_addr_o, 64'h2800_0000);
        msi_if.msi_ready_i = 1'b1; step();
        chk("t3_accept", 64'(msi_if.msi_valid_o), 64'd0);
        irq_src[2] = 1'b0; step();
        irq_src[2] = 1'b1; step(); step();
        chk("t3_new_eiid", 64'(msi_if.msi_data_o), 64'd20);
        step();
        irq_src[2] = 1'b0; step();

        // Illegal file index / zero EIID never pend, even once enabled later
        n0 = n_msi;
        wr(8, 16'h9005); wr(9, 16'h8000);
        irq_src[8] = 1'b1; irq_src[9] = 1'b1;
        repeat (4) step();
        chk("t4_no_valid", 64'(msi_if.msi_valid_o), 64'd0);
        chk("t4_pend", 64'(dut.pend_q[9:8]), 64'd0);
        wr(8, 16'h8805); wr(9, 16'h8009);
        repeat (4) step();
        chk("t4_count", 64'(n_msi - n0), 64'd0);
        irq_src[8] = 1'b0; irq_src[9] = 1'b0;
        wr(8, 16'h0000); wr(9, 16'h0000);

        // Level-mode source held high
        wr(10, 16'hC00B);
        n0 = n_msi;
        irq_src[10] = 1'b1;
        repeat (12) step();
        irq_src[10] = 1'b0;
        repeat (4) step();
        chk("t5_count", 64'(n_msi - n0), LevelEn ? 64'd6 : 64'd1);
        wr(10, 16'h0000);

        // Domain disabled with pending edges, then drain in priority order
        ie = 1'b0; acc_q.delete();
        irq_src[2] = 1'b1; irq_src[4] = 1'b1; irq_src[6] = 1'b1;
        repeat (5) step();
        chk("t6_blocked", 64'(msi_if.msi_valid_o), 64'd0);
        ie = 1'b1;
        repeat (7) step();
        chk("t6_n", 64'(acc_q.size()), 64'd3);
        if (acc_q.size() == 3) begin
            chk("t6_ord0", 64'(acc_q[0]), 64'd20);
            chk("t6_ord1", 64'(acc_q[1]), 64'd10);
            chk("t6_ord2", 64'(acc_q[2]), 64'd7);
        end
        irq_src = '0; step();

        // Reset while sending loses the message
        msi_if.msi_ready_i = 1'b0;
        irq_src[2] = 1'b1; step(); step();
        chk("t7_sending", 64'(msi_if.msi_valid_o), 64'd1);
        rst = 1'b1; step();
        chk("t7_rst_valid", 64'(msi_if.msi_valid_o), 64'd0);
        chk("t7_rst_addr", msi_if.msi_addr_o, 64'd0);
        chk("t7_rst_data", 64'(msi_if.msi_data_o), 64'd0);
        rst = 1'b0; msi_if.msi_ready_i = 1'b1; n0 = n_msi;
        repeat (5) step();
        chk("t7_after", 64'(msi_if.msi_valid_o), 64'd0);
        chk("t7_count", 64'(n_msi - n0), 64'd0);
        irq_src = '0; step();

        // Randomized traffic against the model
        for (int i = 0; i < NS; i++)
            wr(i, 16'($urandom) | (($urandom_range(0, 3) != 0) ? 16'h8000 : 16'h0000));
        n0 = n_msi;
        m_acc = 0;
        for (int c = 0; c < 800; c++) begin
            irq_src = 30'($urandom & $urandom & $urandom);
            msi_if.msi_ready_i = ($urandom_range(0, 2) != 0);
            ie = ($urandom_range(0, 7) != 0);
            we = ($urandom_range(0, 9) == 0);
            idx = 5'($urandom);
            cdata = 16'($urandom);
            if ($urandom_range(0, 49) == 0) base = {$urandom, $urandom};
            step();
        end
        we = 1'b0;
        chk("rand_count", 64'(n_msi - n0), 64'(m_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aia_msi_gen.md
# aia_msi_gen

MSI generator for the AIA interrupt path: samples wired interrupt sources, holds a per-source pending bit, picks the highest-priority pending source and emits one MSI write (address, EIID) toward the hart's IMSIC interrupt files (M, S, and optional VS files). It is the sending end of the MSI interface that the interrupt files receive, sitting between platform interrupt lines and the core's memory-mapped interrupt-file window.

## Interface
- NrSources, 30: wired sources; `irq_src_i[i]` is source number i+1 (source 0 reserved).
- NrIntpFiles, 2: target interrupt files (M, S, then VS files); legal range 1..8.
- AddrWidth, 64: MSI address width.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous and active-high.
- irq_src_i  in  NrSources  wired interrupt inputs, synchronous to clk_i.
- domain_ie_i  in  1  global enable; low = no new MSI started.
- cfg_we_i  in  1  write strobe for the source table.
- cfg_idx_i  in  $clog2(NrSources)  table index (0-based).
- cfg_data_i  in  16  [10:0] EIID, [13:11] file index, [14] mode (1 = level-high, 0 = rising edge), [15] enable.
- msi_base_i  in  AddrWidth  address of file 0; file f at msi_base_i + f*0x1000.
- msi_valid_o  out  1  MSI write request.
- msi_ready_i  in  1  request accepted.
- msi_addr_o  out  AddrWidth  target address.
- msi_data_o  out  32  EIID, zero-extended.
- busy_o  out  1  high in SEND.

## Operation
- Source table: one 16-bit entry per source, written when `cfg_we_i` (index ≥ NrSources ignored). A source is *active* when enable=1, EIID≠0 and file index < NrIntpFiles; otherwise its pending bit is held at 0.
- Edge mode: pending set when `irq_src_i[i]`=1 and previous-cycle sample=0. Level mode: pending set every cycle the input is 1.
- Arbitration: lowest source number among pending&active wins (fixed priority).
- FSM:
  - IDLE: if `domain_ie_i` and any winner, latch its index, compute `msi_addr_o` = msi_base_i + file*0x1000 (modulo 2^AddrWidth) and `msi_data_o` = EIID; go SEND.
  - SEND: `msi_valid_o`=1, addr/data stable. On `msi_ready_i`: clear pending of latched source, go IDLE.
- In-flight message is immutable: table writes, disable, or `domain_ie_i` falling during SEND do not alter or abort it.
- A set event on the in-flight source in the acceptance cycle wins over the clear (pending stays 1).
- Level source still high after acceptance re-pends and produces another MSI.

## Timing
- Reset: `msi_valid_o`=0, `msi_addr_o`=0, `msi_data_o`=0, `busy_o`=0, FSM=IDLE, all pending=0, all table entries=0, previous samples=0.
- Edge at input in cycle 0 → pending visible cycle 1 → `msi_valid_o` high cycle 2.
- Table write in cycle 0 takes effect for arbitration in cycle 1.
- Acceptance in cycle k → `msi_valid_o` low in k+1 (IDLE) → next MSI valid earliest k+2; max throughput one MSI per 2 cycles.
- `msi_valid_o` never drops without `msi_ready_i`; no combinational path from `msi_ready_i` to any output.
- Reset asserted mid-SEND: outputs return to reset values next edge; message is lost, no pending retained.

## Configuration
- `AIA_MSI_LEVEL_EN`: defined → mode bit honoured, level-high sources supported. Undefined → mode bit ignored, every source edge-triggered; level logic not built.

## Test plan
- Source 5 (index 4) cfg 0x800A|file 1 (EIID 10, file 1, edge), base 0x2800_0000, edge at cycle 0, ready=1 → valid at cycle 2, addr 0x2800_1000, data 10, single MSI.
- Sources 3 and 7 edge same cycle, both active → MSI for source 3 first, source 7 at earliest two cycles after acceptance.
- Hold ready=0 for 20 cycles while rewriting the in-flight entry (EIID 20) → addr/data unchanged, valid held; after accept, later MSI for that source uses EIID 20.
- File index 2 with NrIntpFiles=2, or EIID 0 → no MSI ever issued; pending stays 0.
- With `AIA_MSI_LEVEL_EN`, level source held high, ready=1 → MSI every 2 cycles; without macro → exactly one MSI.
- `domain_ie_i`=0 with pending edges → no MSI; raise to 1 → MSIs drain in priority order; reset in SEND → valid=0 next cycle, no MSI afterwards.
